// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned multiplier: one shift-and-add step per RUN cycle,
// four steps per operation, result published with a one-cycle done pulse.
module mult4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_mcand;
  logic [7:0] r_work;
  logic [1:0] r_cnt;
  logic [7:0] r_product;

  logic [3:0] w_addend;
  logic [4:0] w_sum;
  logic [7:0] w_shifted;

  // Single 4-bit adder, carry-in 0; bit 4 of the result is the carry-out.
  function automatic logic [4:0] add4(input logic [3:0] x, input logic [3:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // {carry, high, low} after the add, shifted right by one; bit 0 falls off.
  assign w_addend  = r_work[0] ? r_mcand : 4'd0;
  assign w_sum     = add4(r_work[7:4], w_addend);
  assign w_shifted = {w_sum, r_work[3:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= 4'd0;
      r_work    <= 8'd0;
      r_cnt     <= 2'd0;
      r_product <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_work  <= {4'd0, b};
            r_cnt   <= 2'd0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_work <= w_shifted;
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_product <= w_shifted;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_mult4_seq.sv
// Scoreboard bench for mult4_seq: the driver pushes a*b and the cycle at
// which done is due; an independent negedge monitor pops and compares.
module tb_mult4_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  mult4_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  typedef struct {
    logic [7:0] prod;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy && done) check("busy_done_exclusive", 1, 0);
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("product", int'(product), int'(e.prod));
          check("done_cycle", cyc, e.cyc);
          check("busy_cycles", busy_cnt, 4);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("wait_idle_timeout", 1, 0);
  endtask

  // Issue one operation; acceptance happens at the next rising edge, and
  // done must then appear after four further edges.
  task automatic op(input logic [3:0] xa, input logic [3:0] xb);
    exp_t e;
    wait_idle();
    a = xa;
    b = xb;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.prod = 8'(xa * xb);
    e.cyc  = cyc + 4;
    q.push_back(e);
    start = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [3:0] ta;
    logic [3:0] tb;
    rst_n = 1'b0;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    #3;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_product", int'(product), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed products
    op(4'd0, 4'd0);
    op(4'd15, 4'd15);
    op(4'd7, 4'd3);
    op(4'd1, 4'd15);

    // start held high: accepted only every 6 cycles
    wait_idle();
    a = 4'd0;
    b = 4'd0;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      ta = 4'((3 * i) % 16);
      tb = 4'((7 * i) % 16);
      e.prod = 8'(ta * tb);
      e.cyc  = cyc + 4;
      q.push_back(e);
      a = 4'((3 * (i + 1)) % 16);
      b = 4'((7 * (i + 1)) % 16);
      if (i == 7) start = 1'b0;
      else repeat (5) @(posedge clk);
    end

    // Inputs disturbed during RUN and DONE
    wait_idle();
    a = 4'd9;
    b = 4'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.prod = 8'h51;
    e.cyc  = cyc + 4;
    q.push_back(e);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = (k % 2 == 0);
      a = 4'(k * 5 + 1);
      b = 4'(15 - k);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset in the second RUN cycle aborts the operation
    wait_idle();
    a = 4'd15;
    b = 4'd15;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_product", int'(product), 0);
    repeat (2) @(negedge clk);
    check("abort_hold_product", int'(product), 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_product_after", int'(product), 0);
    op(4'd2, 4'd5);

    // Exhaustive sweep
    for (int i = 0; i < 256; i++) op(4'(i / 16), 4'(i % 16));

    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult4_seq.md
MULT4_SEQ -- requirements
Module: mult4_seq

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits, product width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to multiply a*b; sampled on rising clk edge.
REQ-005 a  input  4  multiplicand, unsigned; sampled only when start is accepted.
REQ-006 b  input  4  multiplier, unsigned; sampled only when start is accepted.
REQ-007 busy  output  1  high while a multiplication is in progress (RUN state).
REQ-008 done  output  1  one-cycle pulse; product is valid and newly updated.
REQ-009 product  output  8  unsigned a*b of the last completed operation; registered.

Function
REQ-010 The block SHALL implement shift-and-add multiplication using one 4-bit add with carry-in 0 and carry-out per RUN cycle.
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 IDLE: when start=1, the block SHALL latch a into the multiplicand register and b into the low nibble of the working register, clear the high nibble and carry, clear the step counter, and go to RUN.
REQ-013 IDLE with start=0: the FSM SHALL stay in IDLE with all registers unchanged.
REQ-014 Each RUN cycle: if working[0]=1, {carry,high} SHALL become high+multiplicand; otherwise {carry,high} = {0,high}. Then {carry,high,low} SHALL shift right one bit.
REQ-015 The RUN step counter (2 bits) SHALL increment once per RUN cycle; after the 4th step (counter=3) the FSM SHALL go to DONE.
REQ-016 On entry to DONE, product SHALL be loaded with the 8-bit working register.
REQ-017 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE unconditionally.
REQ-018 Latency: start accepted at edge N -> busy=1 during cycles N+1..N+4 -> done=1 and new product during cycle N+5 -> IDLE at N+6.
REQ-019 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both are registered-state decodes with no combinational path from inputs.
REQ-020 start SHALL be ignored in RUN and DONE; no queueing; a, b changes after acceptance SHALL NOT affect the result.
REQ-021 start asserted in the cycle after DONE (FSM in IDLE) SHALL be accepted normally; back-to-back operations have a 6-cycle period.
REQ-022 product SHALL hold its value from DONE until the next DONE, including through IDLE and RUN.
REQ-023 The result SHALL be exact for all 256 operand pairs; the maximum 15*15=225 (0xE1) SHALL fit without overflow.

Reset
REQ-024 While rst_n=0, state SHALL be IDLE, busy=0, done=0, product=8'h00, and all internal registers zero, irrespective of clk.
REQ-025 Assertion of rst_n mid-RUN or during DONE SHALL abort the operation immediately; no done pulse SHALL follow, and product SHALL read 0.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-027 Reset, then start with a=0, b=0 -> done at N+5, product=0x00; busy high for exactly 4 cycles.
REQ-028 a=15, b=15 -> product=0xE1 at done; then a=7, b=3 -> 0x15; then a=1, b=15 -> 0x0F. Each result is checked against a*b.
REQ-029 start held high continuously with a=3*i%16, b=7*i%16 for i=0..7 -> accepted every 6 cycles only; each product equals a*b; busy and done are never high together.
REQ-030 Accept a=9, b=9; toggle start and change a/b during RUN and DONE -> exactly one done pulse, product=0x51.
REQ-031 Accept a=15, b=15; drive rst_n=0 between clk edges in the 2nd RUN cycle -> busy, done and product go to 0 without waiting for a clk edge; no done pulse follows; the next start with a=2, b=5 gives 0x0A.
REQ-032 An exhaustive sweep of all 256 a,b pairs checks each product against a*b and confirms a 5-cycle start-to-done latency.
